// File: rtl/matvec_mac_engine.sv
// matvec_mac_engine: signed fixed-point y[c] = sum_r x[r]*W[r][c] with an indexed result bank.
// Build option MATVEC_SAT_EN: clamp overflowing sums instead of wrapping to DATA_W bits.
module matvec_mac_engine #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int VEC_LEN   = 4,
    parameter int OUT_LEN   = 4,
    localparam int ROW_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
    localparam int COL_W    = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic [COL_W-1:0]  rd_sel,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [DATA_W-1:0] data_out,
    output logic [ROW_W-1:0]  x_addr,
    output logic [ROW_W-1:0]  w_row,
    output logic [COL_W-1:0]  w_col
);

    // IDLE: wait for start | CLEAR: zero bank and flags | RUN: one MAC per cycle
    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

    localparam logic signed [2*DATA_W:0] MAX_V = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W:0] MIN_V = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t state, state_nxt;

    logic [DATA_W-1:0]          acc [OUT_LEN];
    logic [DATA_W-1:0]          acc_cur;
    logic [DATA_W-1:0]          acc_nxt;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] prod_sh;
    logic signed [2*DATA_W:0]   sum;
    logic                       sum_ovf;
    logic                       last;

    assign last  = (x_addr == ROW_W'(VEC_LEN-1)) && (w_col == COL_W'(OUT_LEN-1));
    assign ready = (state == IDLE);
    assign busy  = (state == CLEAR) || (state == RUN);
    assign w_row = x_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            RUN:     if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sum is formed one bit wider than the product so the overflow test is exact
    always_comb begin
        acc_cur = acc[w_col];
        prod    = $signed({{DATA_W{x_in[DATA_W-1]}}, x_in}) *
                  $signed({{DATA_W{w_in[DATA_W-1]}}, w_in});
        prod_sh = prod >>> FRAC_BITS;
        sum     = {{(DATA_W+1){acc_cur[DATA_W-1]}}, acc_cur} + {prod_sh[2*DATA_W-1], prod_sh};
        sum_ovf = (sum > MAX_V) || (sum < MIN_V);
`ifdef MATVEC_SAT_EN
        if (sum > MAX_V)      acc_nxt = {1'b0, {(DATA_W-1){1'b1}}};
        else if (sum < MIN_V) acc_nxt = {1'b1, {(DATA_W-1){1'b0}}};
        else                  acc_nxt = sum[DATA_W-1:0];
`else
        acc_nxt = sum[DATA_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_addr <= '0;
            w_col  <= '0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            for (int i = 0; i < OUT_LEN; i++) acc[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                CLEAR: begin
                    x_addr <= '0;
                    w_col  <= '0;
                    ovf    <= 1'b0;
                    for (int i = 0; i < OUT_LEN; i++) acc[i] <= '0;
                end
                RUN: begin
                    acc[w_col] <= acc_nxt;
                    if (sum_ovf) ovf <= 1'b1;
                    if (last) begin
                        x_addr <= '0;
                        w_col  <= '0;
                        done   <= 1'b1;
                    end else if (w_col == COL_W'(OUT_LEN-1)) begin
                        w_col  <= '0;
                        x_addr <= x_addr + ROW_W'(1);
                    end else begin
                        w_col  <= w_col + COL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        if ({1'b0, rd_sel} < (COL_W+1)'(OUT_LEN)) data_out = acc[rd_sel];
    end

endmodule
